// File: rtl/restoring_divider8.sv
// 8-bit unsigned restoring divider: one quotient bit per cycle, result 8 cycles after accept.
// Define RESTORING_DIVIDER8_DIV0_EN to short-circuit divisor==0 (one-edge result, div_by_zero=1).
module restoring_divider8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [7:0]  prem_q;   // partial remainder; always < divisor between steps, so 8 bits hold it
  logic [7:0]  dvd_q;    // dividend bits shift out of the MSB, quotient bits shift into the LSB
  logic [7:0]  dvs_q;
  logic        busy_q;
  logic        done_q;
  logic [7:0]  quo_q;
  logic [7:0]  rem_q;

  logic [8:0]  prem_shift;
  logic [9:0]  sum;
  logic        borrow;
  logic [8:0]  prem_next;
  logic        unused_prem_msb;

  // One restoring step: difference is prem_shift + ~{0,divisor} + 1, borrow is the inverted carry.
  always_comb begin
    prem_shift = {prem_q, dvd_q[7]};
    sum        = {1'b0, prem_shift} + {1'b0, ~{1'b0, dvs_q}} + 10'd1;
    borrow     = ~sum[9];
    prem_next  = borrow ? prem_shift : sum[8:0];
  end

  assign unused_prem_msb = prem_next[8];

`ifdef RESTORING_DIVIDER8_DIV0_EN
  logic dbz_q;
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      prem_q  <= 8'd0;
      dvd_q   <= 8'd0;
      dvs_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= 8'd0;
      rem_q   <= 8'd0;
`ifdef RESTORING_DIVIDER8_DIV0_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            prem_q  <= 8'd0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= StRun;
`ifdef RESTORING_DIVIDER8_DIV0_EN
            if (divisor == 8'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              quo_q   <= 8'hFF;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
            end
`endif
          end
        end
        StRun: begin
          prem_q <= prem_next[7:0];
          dvd_q  <= {dvd_q[6:0], ~borrow};
          cnt_q  <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            quo_q   <= {dvd_q[6:0], ~borrow};
            rem_q   <= prem_next[7:0];
`ifdef RESTORING_DIVIDER8_DIV0_EN
            dbz_q   <= 1'b0;
`endif
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_restoring_divider8.sv
// Self-checking bench for restoring_divider8: vector table plus hand-written corner sequences.
module tb_restoring_divider8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [7:0] divisor = 8'd0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_total = 0;
  int n_pass  = 0;

`ifdef RESTORING_DIVIDER8_DIV0_EN
  localparam bit Div0En = 1'b1;
`else
  localparam bit Div0En = 1'b0;
`endif

  always #5 clk = ~clk;

  restoring_divider8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One full operation; inputs are scrambled right after accept to show they are not re-read.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] q, input logic [7:0] r);
    int  lat;
    int  busy_n;
    bit  fast;
    fast = Div0En && (b == 8'd0);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    lat      = 0;
    busy_n   = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (busy) busy_n++;
    check($sformatf("latency %0d/%0d", a, b), lat, fast ? 0 : 8);
    check($sformatf("quotient %0d/%0d", a, b), int'(quotient), int'(q));
    check($sformatf("remainder %0d/%0d", a, b), int'(remainder), int'(r));
    check($sformatf("div_by_zero %0d/%0d", a, b), int'(div_by_zero), int'(fast));
    check($sformatf("busy cycles %0d/%0d", a, b), busy_n, fast ? 1 : 9);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("done pulse width %0d/%0d", a, b), int'(done), 0);
    check($sformatf("busy after done %0d/%0d", a, b), int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int gap;
    int done_seen;

    vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0};
    vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5};
    vecs[3] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0};
    vecs[4] = '{a: 8'd200, b: 8'd0,   q: 8'hFF,  r: 8'd200};
    vecs[5] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0};
    vecs[6] = '{a: 8'd128, b: 8'd16,  q: 8'd8,   r: 8'd0};
    vecs[7] = '{a: 8'd77,  b: 8'd10,  q: 8'd7,   r: 8'd7};
    vecs[8] = '{a: 8'd1,   b: 8'd2,   q: 8'd0,   r: 8'd1};
    vecs[9] = '{a: 8'd250, b: 8'd3,   q: 8'd83,  r: 8'd1};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset quotient", int'(quotient), 0);
    check("reset remainder", int'(remainder), 0);
    check("reset div_by_zero", int'(div_by_zero), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

    // start held high during RUN/DONE must not queue; it is taken once back in IDLE
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd3;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("ignore-start latency", lat, 8);
    check("ignore-start quotient", int'(quotient), 14);
    check("ignore-start remainder", int'(remainder), 2);
    gap = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      gap++;
    end while (!done && gap < 25);
    start = 1'b0;
    check("back-to-back spacing", gap, 10);
    check("second quotient", int'(quotient), 16);
    check("second remainder", int'(remainder), 2);
    @(posedge clk);
    @(negedge clk);
    check("idle after second", int'(busy), 0);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("mid-run busy before reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("async reset busy", int'(busy), 0);
    check("async reset done", int'(done), 0);
    check("async reset quotient", int'(quotient), 0);
    check("async reset remainder", int'(remainder), 0);
    check("async reset div_by_zero", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("no done after abort", done_seen, 0);
    run_op(8'd9, 8'd2, 8'd4, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
